serial_byte_loader: RTL and testbench

- Deserialiser directly upstream of the 8-bit enable register.
- Shifts a serial bitstream into a parallel word after a start strobe.
- Presents the word on byte_out with a one-cycle load_en pulse, which drives the register's en input; byte_out drives its in.
- Single clock domain, shared with the register.

---
 rtl/cocc_pkg.sv | 14 +
 rtl/serial_byte_loader_if.sv | 22 ++
 rtl/serial_byte_loader_bit_counter.sv | 33 +++
 rtl/serial_byte_loader.sv | 108 ++++++++++
 tb/tb_serial_byte_loader.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/cocc_pkg.sv
// Shared types and constants for the serial byte loader.
// The loader FSM encoding is fixed so it can be probed consistently across builds.
package cocc_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        PARITY = 2'b10,
        DONE   = 2'b11
    } loader_state_t;

endpackage

// File: rtl/serial_byte_loader_if.sv
// Serial-in / parallel-out bundle between the bit source and the loader.
// SERIAL_LOADER_PARITY_EN adds the parity_err pulse to the bundle.
interface serial_byte_loader_if import cocc_pkg::*; #(
    parameter int WIDTH = BYTE_W
) ();

    logic             start;
    logic             sdata;
    logic [WIDTH-1:0] byte_out;
    logic             load_en;
    logic             busy;
`ifdef SERIAL_LOADER_PARITY_EN
    logic             parity_err;

    modport master (output start, sdata, input byte_out, load_en, busy, parity_err);
    modport slave  (input start, sdata, output byte_out, load_en, busy, parity_err);
`else
    modport master (output start, sdata, input byte_out, load_en, busy);
    modport slave  (input start, sdata, output byte_out, load_en, busy);
`endif

endinterface

// File: rtl/serial_byte_loader_bit_counter.sv
// Frame bit counter: synchronous clear, saturating increment, terminal count at WIDTH-1.
module bit_counter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tc = (cnt_q == CNT_W'(WIDTH - 1));

    // Holding at the terminal value keeps the count from ever wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && !tc)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/serial_byte_loader.sv
// Serial-to-parallel loader feeding the enable register: WIDTH bits after start, then a load_en pulse.
// Optional even-parity check under macro SERIAL_LOADER_PARITY_EN.
module serial_byte_loader import cocc_pkg::*; #(
    parameter int WIDTH     = BYTE_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_byte_loader_if.slave bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    loader_state_t    state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d, shift_nxt;
    logic [WIDTH-1:0] byte_q, byte_d;
    logic             cnt_clr, cnt_inc, cnt_tc;
`ifdef SERIAL_LOADER_PARITY_EN
    logic             ok_q, ok_d, par_ok;

    // Even parity: data bits plus parity bit must XOR to zero.
    assign par_ok = ~(^{shift_q, bus.sdata});
`endif

    bit_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_bit_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .tc    (cnt_tc)
    );

    always_comb begin
        if (MSB_FIRST)
            shift_nxt = {shift_q[WIDTH-2:0], bus.sdata};
        else
            shift_nxt = {bus.sdata, shift_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
`ifdef SERIAL_LOADER_PARITY_EN
        ok_d    = ok_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                if (bus.start)
                    state_d = SHIFT;
            end
            SHIFT: begin
                shift_d = shift_nxt;
                cnt_inc = 1'b1;
                if (cnt_tc) begin
`ifdef SERIAL_LOADER_PARITY_EN
                    state_d = PARITY;
`else
                    byte_d  = shift_nxt;
                    state_d = DONE;
`endif
                end
            end
`ifdef SERIAL_LOADER_PARITY_EN
            PARITY: begin
                ok_d = par_ok;
                if (par_ok)
                    byte_d = shift_q;
                state_d = DONE;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            byte_q  <= '0;
`ifdef SERIAL_LOADER_PARITY_EN
            ok_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
`ifdef SERIAL_LOADER_PARITY_EN
            ok_q    <= ok_d;
`endif
        end
    end

    // All handshake outputs come straight from registered state.
    assign bus.busy     = (state_q != IDLE);
    assign bus.byte_out = byte_q;
`ifdef SERIAL_LOADER_PARITY_EN
    assign bus.load_en    = (state_q == DONE) && ok_q;
    assign bus.parity_err = (state_q == DONE) && !ok_q;
`else
    assign bus.load_en    = (state_q == DONE);
`endif

endmodule

// File: tb/tb_serial_byte_loader.sv
// Scoreboard bench: drives one bitstream into an MSB-first and an LSB-first loader in parallel,
// predicting each loaded word and its load cycle from the transmitted bit sequence.
module tb_serial_byte_loader;
    import cocc_pkg::*;

    localparam int W = BYTE_W;
`ifdef SERIAL_LOADER_PARITY_EN
    localparam int PX = 1;
`else
    localparam int PX = 0;
`endif

    typedef struct {
        logic [W-1:0] data;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_byte_loader_if #(.WIDTH(W)) bm ();
    serial_byte_loader_if #(.WIDTH(W)) bl ();

    serial_byte_loader #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(bm.slave));
    serial_byte_loader #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(bl.slave));

    exp_t         qm[$];
    exp_t         ql[$];
    int           qem[$];
    int           qel[$];
    exp_t         em, el;
    logic [W-1:0] last_m = '0;
    logic [W-1:0] last_l = '0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic s, input logic d);
        bm.start = s; bl.start = s;
        bm.sdata = d; bl.sdata = d;
    endtask

    task automatic chk_busy(input logic exp, input string name);
        chk({name, "_m"}, bm.busy, exp);
        chk({name, "_l"}, bl.busy, exp);
    endtask

    // Transmit data[W-1] first; bad=1 sends a wrong parity bit (parity builds only).
    task automatic send(input logic [W-1:0] data, input bit hold, input bit bad);
        logic [W-1:0] wm, wl;
        int t0;
        @(negedge clk);
        drive(1'b1, 1'($urandom));
        t0 = cyc;
        for (int i = 0; i < W; i++) begin
            wm[W-1-i] = data[W-1-i];   // i-th bit on the wire lands at the top for MSB-first
            wl[i]     = data[W-1-i];   // and at position i for LSB-first
        end
        if (bad && PX == 1) begin
            qem.push_back(t0 + W + 1 + PX);
            qel.push_back(t0 + W + 1 + PX);
        end else begin
            qm.push_back('{data: wm, cyc: t0 + W + 1 + PX});
            ql.push_back('{data: wl, cyc: t0 + W + 1 + PX});
        end
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            drive(hold | 1'($urandom), data[W-1-i]);
            chk_busy(1'b1, "busy_shift");
        end
        if (PX == 1) begin
            @(negedge clk);
            drive(hold | 1'($urandom), (^data) ^ bad);
            chk_busy(1'b1, "busy_parity");
        end
        @(negedge clk);
        drive(1'($urandom), 1'($urandom));
        chk_busy(1'b1, "busy_done");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(1'b0, 1'($urandom));
            chk_busy(1'b0, "busy_idle");
        end
    endtask

    task automatic check_reset_outs(input string name);
        chk({name, "_byte_m"}, bm.byte_out, 0);
        chk({name, "_byte_l"}, bl.byte_out, 0);
        chk({name, "_load_m"}, bm.load_en, 0);
        chk({name, "_load_l"}, bl.load_en, 0);
        chk_busy(1'b0, {name, "_busy"});
`ifdef SERIAL_LOADER_PARITY_EN
        chk({name, "_perr_m"}, bm.parity_err, 0);
`endif
    endtask

    // Monitor: every load_en pops an expectation; otherwise byte_out must hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_m = '0;
            last_l = '0;
        end else begin
            if (bm.load_en) begin
                if (qm.size() == 0) chk("m_spurious_load", bm.load_en, 0);
                else begin
                    em = qm.pop_front();
                    chk("m_byte", bm.byte_out, em.data);
                    chk("m_load_cyc", cyc, em.cyc);
                    last_m = em.data;
                end
            end else chk("m_hold", bm.byte_out, last_m);
            if (bl.load_en) begin
                if (ql.size() == 0) chk("l_spurious_load", bl.load_en, 0);
                else begin
                    el = ql.pop_front();
                    chk("l_byte", bl.byte_out, el.data);
                    chk("l_load_cyc", cyc, el.cyc);
                    last_l = el.data;
                end
            end else chk("l_hold", bl.byte_out, last_l);
`ifdef SERIAL_LOADER_PARITY_EN
            if (bm.parity_err) begin
                if (qem.size() == 0) chk("m_spurious_perr", bm.parity_err, 0);
                else chk("m_perr_cyc", cyc, qem.pop_front());
            end
            if (bl.parity_err) begin
                if (qel.size() == 0) chk("l_spurious_perr", bl.parity_err, 0);
                else chk("l_perr_cyc", cyc, qel.pop_front());
            end
`endif
        end
    end

    initial begin
        bit hold;
        drive(1'b0, 1'b0);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'($urandom), 1'($urandom));
            #1 check_reset_outs("in_reset");
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        drive(1'b0, 1'($urandom));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b0, 1'($urandom));
            check_reset_outs("post_reset");
        end

        // Directed frames
        send(8'hA5, 1'b0, 1'b0); idle(2);
        send(8'h80, 1'b0, 1'b0); idle(1);
        send(8'h3C, 1'b1, 1'b0);
        send(8'hC3, 1'b1, 1'b0); idle(2);

        // Abort after four bits of 8'hFF
        @(negedge clk); drive(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); drive(1'b0, 1'b1);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outs("abort");
        @(negedge clk); drive(1'b0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        idle(2);
        send(8'h81, 1'b0, 1'b0); idle(1);

`ifdef SERIAL_LOADER_PARITY_EN
        send(8'h0F, 1'b0, 1'b0); idle(1);
        send(8'h0F, 1'b0, 1'b1); idle(1);
        send(8'h5A, 1'b0, 1'b1); idle(1);
`endif

        // Randomized frames
        hold = 1'b0;
        for (int f = 0; f < 24; f++) begin
            hold = 1'($urandom);
            send(W'($urandom), hold, (PX == 1) && ($urandom_range(0, 3) == 0));
            if (!hold) idle($urandom_range(0, 3));
        end
        idle(W + 6);

        chk("m_pending_loads", qm.size(), 0);
        chk("l_pending_loads", ql.size(), 0);
        chk("m_pending_perr", qem.size(), 0);
        chk("l_pending_perr", qel.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
